// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment scanner: scan states,
// active-low segment patterns ordered {g,f,e,d,c,b,a}, and the anode-off value.
package seven_segment_pkg;

  typedef enum logic [2:0] {
    BLANK,
    D0,
    D1,
    D2,
    D3
  } scanState_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Digit position driven in each scan state; BLANK never lights anything,
  // so its index is irrelevant.
  function automatic logic [1:0] slotIndex(input scanState_t s);
    case (s)
      D1:      slotIndex = 2'd1;
      D2:      slotIndex = 2'd2;
      D3:      slotIndex = 2'd3;
      default: slotIndex = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_segment.sv
// Combinational BCD to active-low seven-segment decoder; codes A-F show a dash.
module bcd_to_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segment
);

  always_comb begin
    segment = SEG_DASH;
    case (bcd)
      4'd0:    segment = SEG_0;
      4'd1:    segment = SEG_1;
      4'd2:    segment = SEG_2;
      4'd3:    segment = SEG_3;
      4'd4:    segment = SEG_4;
      4'd5:    segment = SEG_5;
      4'd6:    segment = SEG_6;
      4'd7:    segment = SEG_7;
      4'd8:    segment = SEG_8;
      4'd9:    segment = SEG_9;
      default: segment = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot and registered outputs.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int CounterWidth = 17,
  parameter int RefreshTime  = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DigitEnable,
  output logic [3:0]  Anode,
  output logic [6:0]  Segment,
  output logic        Frame
);

  localparam logic [CounterWidth-1:0] LastCount = CounterWidth'(RefreshTime - 1);

  logic [CounterWidth-1:0] prescaler;
  logic                    tick;
  scanState_t              state, nextState;
  logic                    loadSnap;
  logic [15:0]             snapData, nextSnapData;
  logic [3:0]              snapEnable, nextSnapEnable;
  logic [3:0]              litMask;
  logic [1:0]              slot;
  logic [3:0]              nibble;
  logic [6:0]              decoded;
  logic [3:0]              nextAnode;
  logic [6:0]              nextSegment;

  assign tick = (prescaler == LastCount);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + CounterWidth'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= BLANK;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    loadSnap  = 1'b0;
    if (tick) begin
      case (state)
        BLANK, D3: begin
          nextState = D0;
          loadSnap  = 1'b1;
        end
        D0:      nextState = D1;
        D1:      nextState = D2;
        D2:      nextState = D3;
        default: nextState = BLANK;
      endcase
    end
  end

  // Outputs are computed from the post-edge snapshot so that the digit shown on
  // entry to D0 already comes from the freshly captured data.
  always_comb begin
    nextSnapData   = loadSnap ? DataIn : snapData;
    nextSnapEnable = loadSnap ? DigitEnable : snapEnable;
    litMask        = nextSnapEnable;
`ifdef LEADING_ZERO_BLANK_EN
    if (nextSnapData[15:12] == 4'd0) litMask[3] = 1'b0;
    if (nextSnapData[15:8]  == 8'd0) litMask[2] = 1'b0;
    if (nextSnapData[15:4]  == 12'd0) litMask[1] = 1'b0;
`endif
  end

  always_comb begin
    slot = slotIndex(nextState);
    case (slot)
      2'd1:    nibble = nextSnapData[7:4];
      2'd2:    nibble = nextSnapData[11:8];
      2'd3:    nibble = nextSnapData[15:12];
      default: nibble = nextSnapData[3:0];
    endcase
  end

  bcd_to_segment decoder (
    .bcd     (nibble),
    .segment (decoded)
  );

  always_comb begin
    nextAnode   = ANODE_OFF;
    nextSegment = SEG_BLANK;
    if (nextState != BLANK && litMask[slot]) begin
      nextAnode   = ~(4'b0001 << slot);
      nextSegment = decoded;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      snapData   <= '0;
      snapEnable <= '0;
      Anode      <= ANODE_OFF;
      Segment    <= SEG_BLANK;
      Frame      <= 1'b0;
    end else begin
      snapData   <= nextSnapData;
      snapEnable <= nextSnapEnable;
      Anode      <= nextAnode;
      Segment    <= nextSegment;
      Frame      <= loadSnap;
    end
  end

endmodule
